// File: rtl/uart_peripheral.sv
// uart_peripheral: memory-mapped 8N1 UART bus slave (one TX holding byte, one RX byte).
//
// Ports:
//   clk      system clock (single domain)
//   reset    synchronous active-high reset
//   CS_N     chip select, active low
//   RD_N     read strobe, active low
//   WR_N     write strobe, active low
//   Addr     byte offset, only [3:2] decoded (0 DATA, 4 STATUS, 8 CTRL, C BAUD)
//   DataIn   write data
//   DataOut  combinational read data, 0 when deselected
//   Intr     level interrupt, active high
//   RXD      serial input, asynchronous, idle high
//   TXD      serial output, idle high
module uart_peripheral #(
    parameter int unsigned DEFAULT_DIV = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS_N,
    input  logic        RD_N,
    input  logic        WR_N,
    input  logic [11:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Intr,
    input  logic        RXD,
    output logic        TXD
);

    localparam logic [1:0] AddrData   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrBaud   = 2'd3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    localparam logic [15:0] DefaultBaud = 16'(DEFAULT_DIV);

    // ---------------- bus decode ----------------
    logic [1:0] reg_sel;
    logic       wr_acc, rd_acc, read_edge;
    logic       wr_data, wr_status, wr_ctrl, wr_baud, data_rd_edge;
    logic       rd_prev_q;
    logic [1:0] rd_sel_q;

    assign reg_sel   = Addr[3:2];
    assign wr_acc    = ~CS_N & ~WR_N;
    assign rd_acc    = ~CS_N & ~RD_N & WR_N;
    // Only the first cycle of a held read to one offset has side effects.
    assign read_edge = rd_acc & ~(rd_prev_q & (rd_sel_q == reg_sel));

    assign wr_data      = wr_acc & (reg_sel == AddrData);
    assign wr_status    = wr_acc & (reg_sel == AddrStatus);
    assign wr_ctrl      = wr_acc & (reg_sel == AddrCtrl);
    assign wr_baud      = wr_acc & (reg_sel == AddrBaud);
    assign data_rd_edge = read_edge & (reg_sel == AddrData);

    logic unused_bus;
    assign unused_bus = ^{Addr[11:4], Addr[1:0], DataIn[31:16]};

    // ---------------- registers ----------------
    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        tick;

    logic       tx_en, rx_en, rx_ie, tx_ie;
    assign tx_en = ctrl_q[0];
    assign rx_en = ctrl_q[1];
    assign rx_ie = ctrl_q[2];
    assign tx_ie = ctrl_q[3];

    assign tick = (baud_cnt_q == baud_q);

    always_comb begin
        ctrl_d     = wr_ctrl ? DataIn[3:0] : ctrl_q;
        baud_d     = wr_baud ? DataIn[15:0] : baud_q;
        baud_cnt_d = (wr_baud || tick) ? 16'd0 : baud_cnt_q + 16'd1;
    end

    // ---------------- transmitter ----------------
    logic [1:0] tx_state_q, tx_state_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0] tx_bcnt_q, tx_bcnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_full_q, tx_full_d;
    logic       tx_load;

    assign tx_load = (tx_state_q == StIdle) & tx_en & tx_full_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;

        if (tx_load) begin
            tx_shift_d = tx_hold_q;
            tx_state_d = StStart;
            tx_tcnt_d  = 4'd0;
            tx_bcnt_d  = 3'd0;
            tx_full_d  = 1'b0;
        end
        // A write landing on the same edge as the transfer refills the holding register.
        if (wr_data && (!tx_full_q || tx_load)) begin
            tx_hold_d = DataIn[7:0];
            tx_full_d = 1'b1;
        end

        if (tx_state_q != StIdle && tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
                case (tx_state_q)
                    StStart: tx_state_d = StData;
                    StData: begin
                        if (tx_bcnt_q == 3'd7) begin
                            tx_state_d = StStop;
                        end else begin
                            tx_bcnt_d  = tx_bcnt_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        end
                    end
                    default: tx_state_d = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        case (tx_state_q)
            StStart: TXD = 1'b0;
            StData:  TXD = tx_shift_q[0];
            default: TXD = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic       rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [1:0] rx_state_q, rx_state_d;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_bcnt_q, rx_bcnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_stop_ok, rx_stop_bad;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tcnt_d   = rx_tcnt_q;
        rx_bcnt_d   = rx_bcnt_q;
        rx_shift_d  = rx_shift_q;
        rx_stop_ok  = 1'b0;
        rx_stop_bad = 1'b0;

        if (!rx_en) begin
            rx_state_d = StIdle;
        end else begin
            case (rx_state_q)
                StIdle: begin
                    if (rx_prev_q && !rx_sync2_q) begin
                        rx_state_d = StStart;
                        rx_tcnt_d  = 4'd0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        rx_tcnt_d = rx_tcnt_q + 4'd1;
                        // Mid start bit: a high line means it was only a glitch.
                        if (rx_tcnt_q == 4'd7) begin
                            rx_tcnt_d  = 4'd0;
                            rx_bcnt_d  = 3'd0;
                            rx_state_d = rx_sync2_q ? StIdle : StData;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        rx_tcnt_d = rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                            if (rx_bcnt_q == 3'd7) begin
                                rx_state_d = StStop;
                            end else begin
                                rx_bcnt_d = rx_bcnt_q + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        rx_tcnt_d = rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_state_d  = StIdle;
                            rx_stop_ok  = rx_sync2_q;
                            rx_stop_bad = ~rx_sync2_q;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- status flags ----------------
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       rx_load, overrun_set;

    // A read edge on DATA frees the buffer in time for a byte completing this cycle.
    assign rx_load     = rx_stop_ok & (~rx_valid_q | data_rd_edge);
    assign overrun_set = rx_stop_ok & rx_valid_q & ~data_rd_edge;

    always_comb begin
        rx_byte_d   = rx_load ? rx_shift_q : rx_byte_q;
        rx_valid_d  = rx_load ? 1'b1 : (data_rd_edge ? 1'b0 : rx_valid_q);
        overrun_d   = overrun_set | (overrun_q & ~(wr_status & DataIn[3]));
        frame_err_d = rx_stop_bad | (frame_err_q & ~(wr_status & DataIn[4]));
    end

    // ---------------- state update ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_prev_q   <= 1'b0;
            rd_sel_q    <= 2'd0;
            ctrl_q      <= 4'd0;
            baud_q      <= DefaultBaud;
            baud_cnt_q  <= 16'd0;
            tx_state_q  <= StIdle;
            tx_tcnt_q   <= 4'd0;
            tx_bcnt_q   <= 3'd0;
            tx_shift_q  <= 8'd0;
            tx_hold_q   <= 8'd0;
            tx_full_q   <= 1'b0;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= StIdle;
            rx_tcnt_q   <= 4'd0;
            rx_bcnt_q   <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rd_prev_q   <= rd_acc;
            rd_sel_q    <= reg_sel;
            ctrl_q      <= ctrl_d;
            baud_q      <= baud_d;
            baud_cnt_q  <= baud_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_tcnt_q   <= tx_tcnt_d;
            tx_bcnt_q   <= tx_bcnt_d;
            tx_shift_q  <= tx_shift_d;
            tx_hold_q   <= tx_hold_d;
            tx_full_q   <= tx_full_d;
            rx_sync1_q  <= RXD;
            rx_sync2_q  <= rx_sync1_q;
            rx_prev_q   <= rx_sync2_q;
            rx_state_q  <= rx_state_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bcnt_q   <= rx_bcnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- read mux / interrupt ----------------
    logic tx_ready, tx_busy;
    assign tx_ready = ~tx_full_q;
    assign tx_busy  = (tx_state_q != StIdle);

    always_comb begin
        DataOut = 32'd0;
        if (!CS_N) begin
            case (reg_sel)
                AddrData:   DataOut = {24'd0, rx_byte_q};
                AddrStatus: DataOut = {27'd0, frame_err_q, overrun_q, tx_busy, tx_ready,
                                       rx_valid_q};
                AddrCtrl:   DataOut = {28'd0, ctrl_q};
                default:    DataOut = {16'd0, baud_q};
            endcase
        end
    end

    assign Intr = (rx_ie & rx_valid_q) | (tx_ie & tx_en & tx_ready);

endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral: directed self-checking bench for uart_peripheral.
module tb_uart_peripheral;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n, rd_n, wr_n;
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        intr;
    logic        rxd, txd;
    logic        rxd_drv;
    logic        loopback;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rxd = loopback ? txd : rxd_drv;

    uart_peripheral #(.DEFAULT_DIV(26)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS_N    (cs_n),
        .RD_N    (rd_n),
        .WR_N    (wr_n),
        .Addr    (addr),
        .DataIn  (din),
        .DataOut (dout),
        .Intr    (intr),
        .RXD     (rxd),
        .TXD     (txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1ns after a rising edge and leave one idle cycle.
    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(posedge clk); #1;
        cs_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        cs_n = 1'b0; rd_n = 1'b0; addr = a;
        #1 d = dout;
        @(posedge clk); #1;
        cs_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame at 16 clocks per bit (BAUD=0).
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            wait_cycles(16);
        end
        rxd_drv = stop_bit;
        wait_cycles(16);
        rxd_drv = 1'b1;
        wait_cycles(16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        tx_cap [1:160];
    logic [7:0]  tx_byte;
    logic        busy_all;
    logic        all_high;
    logic [15:0] win;
    logic        exp_bit;
    int          waited;

    initial begin
        reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; din = '0; rxd_drv = 1'b1; loopback = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state ----
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_intr", {31'd0, intr}, 32'd0);
        check("rst_dout_desel", dout, 32'd0);
        bus_read(12'h4, rd); check("rst_status", rd, 32'h02);
        bus_read(12'h8, rd); check("rst_ctrl", rd, 32'h00);
        bus_read(12'hC, rd); check("rst_baud", rd, 32'd26);

        // ---- TX 0x55 at BAUD=0 ----
        bus_write(12'hC, 32'd0);
        bus_write(12'h8, 32'h1);
        tx_byte = 8'h55;
        cs_n = 1'b0; wr_n = 1'b0; addr = 12'h0; din = 32'h55;
        @(posedge clk); #1;
        wr_n = 1'b1; rd_n = 1'b0; addr = 12'h4;
        #1 check("tx_status_after_write", dout, 32'h00);
        busy_all = 1'b1;
        for (int c = 1; c <= 161; c++) begin
            @(posedge clk); #1;
            if (c <= 160) begin
                tx_cap[c] = txd;
                busy_all  = busy_all & dout[2];
            end
            if (c == 1) check("tx_status_loaded", dout, 32'h06);
            if (c == 161) begin
                check("tx_idle_txd", {31'd0, txd}, 32'd1);
                check("tx_idle_status", dout, 32'h02);
            end
        end
        cs_n = 1'b1; rd_n = 1'b1;
        check("tx_busy_frame", {31'd0, busy_all}, 32'd1);
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 16; k++) win[k] = tx_cap[1 + 16 * b + k];
            if (b == 0) exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else exp_bit = tx_byte[b - 1];
            check($sformatf("tx_bit%0d", b), {16'd0, win}, exp_bit ? 32'hFFFF : 32'h0);
        end
        @(posedge clk); #1;

        // ---- loopback 0xA5 ----
        loopback = 1'b1;
        bus_write(12'h8, 32'h7);
        bus_write(12'h0, 32'hA5);
        waited = 0;
        while (!intr && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        check("lb_intr_rise", {31'd0, intr}, 32'd1);
        wait_cycles(40);
        bus_read(12'h4, rd); check("lb_status_valid", rd, 32'h03);
        bus_read(12'h0, rd); check("lb_data", rd, 32'hA5);
        check("lb_intr_clear", {31'd0, intr}, 32'd0);
        bus_read(12'h4, rd); check("lb_status_after_read", rd, 32'h02);
        loopback = 1'b0;

        // ---- overrun and W1C ----
        bus_write(12'h8, 32'h2);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(12'h4, rd); check("ovr_status", rd, 32'h0B);
        bus_read(12'h0, rd); check("ovr_data_old", rd, 32'h11);
        bus_write(12'h4, 32'h08);
        bus_read(12'h4, rd); check("ovr_w1c", rd, 32'h02);

        // ---- framing error ----
        send_rx(8'h3C, 1'b0);
        bus_read(12'h4, rd); check("frm_status", rd, 32'h12);
        bus_write(12'h4, 32'h10);
        bus_read(12'h4, rd); check("frm_w1c", rd, 32'h02);

        // ---- 4-tick glitch ----
        rxd_drv = 1'b0;
        wait_cycles(4);
        rxd_drv = 1'b1;
        wait_cycles(100);
        bus_read(12'h4, rd); check("glitch_status", rd, 32'h02);

        // ---- reset during a TX data bit ----
        bus_write(12'h8, 32'h1);
        bus_write(12'h0, 32'hF0);
        wait_cycles(40);
        check("rstmid_txd_running", {31'd0, txd}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_txd", {31'd0, txd}, 32'd1);
        reset = 1'b0;
        bus_read(12'h4, rd); check("rstmid_status", rd, 32'h02);
        bus_read(12'hC, rd); check("rstmid_baud", rd, 32'd26);
        all_high = 1'b1;
        repeat (200) begin
            @(posedge clk); #1;
            all_high = all_high & txd;
        end
        check("rstmid_no_residual", {31'd0, all_high}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
